adjust_sequencer: RTL and testbench

Front-end controller for the clock's set-time datapath. It debounces the four DE2 push-buttons and runs the adjust-mode state machine: entering and leaving adjust mode, walking the field selection, and issuing single-cycle increment/clear commands with press-and-hold auto-repeat. Its `add`, `clr`, `adjust` and `select` outputs drive the time counter and display blocks directly. An idle timeout returns the clock to run mode.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/adjust_sequencer_if.sv | 16 +
 rtl/key_debounce.sv | 50 +++++
 rtl/adjust_sequencer.sv | 151 +++++++++++++++
 tb/tb_adjust_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-time path: field encodings, FSM states
// and the 1 ms tick divisor.
package clock_pkg;

    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_NONE   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_SECOND = 4'd1;
    localparam logic [SEL_W-1:0] SEL_MINUTE = 4'd2;
    localparam logic [SEL_W-1:0] SEL_HOUR   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_DAY    = 4'd4;
    localparam logic [SEL_W-1:0] SEL_MONTH  = 4'd5;
    localparam logic [SEL_W-1:0] SEL_YEAR_L = 4'd6;
    localparam logic [SEL_W-1:0] SEL_YEAR_H = 4'd7;

    localparam logic [SEL_W-1:0] SEL_FIRST = SEL_SECOND;
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_YEAR_H;

    typedef enum logic [1:0] {
        StRun,
        StAdj,
        StHold,
        StRepeat
    } adj_state_e;

    // Cycles per 1 ms tick; never below 1 so slow test clocks tick every cycle.
    function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
        int unsigned div;
        div = clk_hz / 1000;
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/adjust_sequencer_if.sv
// Key inputs and adjust-mode command outputs of the set-time front end.
interface adjust_sequencer_if;
    import clock_pkg::*;

    logic [3:0]       KEY;
    logic             adjust;
    logic [SEL_W-1:0] select;
    logic             add;
    logic             clr;

    // Sequencer side.
    modport slave (input KEY, output adjust, output select, output add, output clr);
    // Button / consumer side.
    modport master (output KEY, input adjust, input select, input add, input clr);

endinterface

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchronizer, ms-tick debounce counter and a
// registered press (1->0) event on the debounced level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]      r_sync;
    logic            r_level;
    logic            r_level_d;
    logic            r_press;
    logic [CntW-1:0] r_cnt;

    // Synchronize, debounce and register the falling edge of the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_key};
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == CntW'(DEBOUNCE_MS - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/adjust_sequencer.sv
// Adjust-mode controller: debounces the four keys, walks the field selection
// and issues single-cycle add/clr commands with press-and-hold auto-repeat.
module adjust_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned IDLE_TIMEOUT_MS = 10_000
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    adjust_sequencer_if.slave   bus
);

    localparam int unsigned TickDiv = ms_tick_div(CLK_HZ);
    localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned RepMax  = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                      REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int unsigned RepW    = $clog2(RepMax + 1);
    localparam int unsigned IdleW   = $clog2(IDLE_TIMEOUT_MS + 1);

    logic [TickW-1:0] r_tick_cnt;
    logic             w_tick;
    logic [3:0]       w_press;
    logic             w_key2_level;

    adj_state_e       r_state, w_state_d;
    logic [SEL_W-1:0] r_select, w_select_d;
    logic             r_adjust, w_adjust_d;
    logic             r_add, w_add_d;
    logic             r_clr, w_clr_d;
    logic [RepW-1:0]  r_rep_cnt, w_rep_d;
    logic [IdleW-1:0] r_idle_cnt, w_idle_d;

    assign w_tick = (r_tick_cnt == TickW'(TickDiv - 1));

    // Shared 1 ms strobe for all debouncers and the repeat/idle counters.
    always_ff @(posedge CLOCK_50) begin
        if (rst || w_tick) r_tick_cnt <= '0;
        else               r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key0 (
        .i_clk(CLOCK_50), .i_rst(rst), .i_tick(w_tick), .i_key(bus.KEY[0]),
        .o_level(), .o_press(w_press[0])
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key1 (
        .i_clk(CLOCK_50), .i_rst(rst), .i_tick(w_tick), .i_key(bus.KEY[1]),
        .o_level(), .o_press(w_press[1])
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key2 (
        .i_clk(CLOCK_50), .i_rst(rst), .i_tick(w_tick), .i_key(bus.KEY[2]),
        .o_level(w_key2_level), .o_press(w_press[2])
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key3 (
        .i_clk(CLOCK_50), .i_rst(rst), .i_tick(w_tick), .i_key(bus.KEY[3]),
        .o_level(), .o_press(w_press[3])
    );

    // Next-state logic; event priority is KEY0 > KEY3 > KEY1 > KEY2, idle timeout above all.
    always_comb begin
        w_state_d  = r_state;
        w_select_d = r_select;
        w_adjust_d = r_adjust;
        w_add_d    = 1'b0;
        w_clr_d    = 1'b0;
        w_rep_d    = r_rep_cnt;
        w_idle_d   = r_idle_cnt;
        if (w_tick) w_idle_d = r_idle_cnt + 1'b1;

        case (r_state)
            StRun: begin
                w_idle_d = '0;
                w_rep_d  = '0;
                if (w_press[0]) begin
                    w_state_d  = StAdj;
                    w_select_d = SEL_FIRST;
                    w_adjust_d = 1'b1;
                end
            end
            StAdj, StHold, StRepeat: begin
                if ((w_tick && r_idle_cnt == IdleW'(IDLE_TIMEOUT_MS - 1)) || w_press[0]) begin
                    w_state_d  = StRun;
                    w_select_d = SEL_NONE;
                    w_adjust_d = 1'b0;
                    w_idle_d   = '0;
                    w_rep_d    = '0;
                end else if (w_press[3]) begin
                    w_state_d = StAdj;
                    w_clr_d   = 1'b1;
                    w_idle_d  = '0;
                end else if (w_press[1]) begin
                    w_state_d  = StAdj;
                    w_select_d = (r_select == SEL_LAST) ? SEL_FIRST : r_select + 1'b1;
                    w_idle_d   = '0;
                end else if (r_state == StAdj) begin
                    if (w_press[2]) begin
                        w_state_d = StHold;
                        w_add_d   = 1'b1;
                        w_rep_d   = '0;
                        w_idle_d  = '0;
                    end
                end else if (w_key2_level) begin
                    // Debounced release ends the auto-repeat.
                    w_state_d = StAdj;
                    w_rep_d   = '0;
                end else if (w_tick) begin
                    if ((r_state == StHold && r_rep_cnt == RepW'(REPEAT_DELAY_MS - 1)) ||
                        (r_state == StRepeat && r_rep_cnt == RepW'(REPEAT_RATE_MS - 1))) begin
                        w_state_d = StRepeat;
                        w_add_d   = 1'b1;
                        w_rep_d   = '0;
                        w_idle_d  = '0;
                    end else begin
                        w_rep_d = r_rep_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state    <= StRun;
            r_select   <= SEL_NONE;
            r_adjust   <= 1'b0;
            r_add      <= 1'b0;
            r_clr      <= 1'b0;
            r_rep_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_select   <= w_select_d;
            r_adjust   <= w_adjust_d;
            r_add      <= w_add_d;
            r_clr      <= w_clr_d;
            r_rep_cnt  <= w_rep_d;
            r_idle_cnt <= w_idle_d;
        end
    end

    assign bus.adjust = r_adjust;
    assign bus.select = r_select;
    assign bus.add    = r_add;
    assign bus.clr    = r_clr;

endmodule

// File: tb/tb_adjust_sequencer.sv
// Directed bench for adjust_sequencer with a 1-cycle ms tick.
module tb_adjust_sequencer;
    import clock_pkg::*;

    localparam int unsigned CLK_HZ          = 1000;
    localparam int unsigned DEBOUNCE_MS     = 4;
    localparam int unsigned REPEAT_DELAY_MS = 10;
    localparam int unsigned REPEAT_RATE_MS  = 3;
    localparam int unsigned IDLE_TIMEOUT_MS = 50;

    typedef struct {
        logic [3:0] mask;   // keys pressed (1 = pressed)
        int         hold;   // cycles held low
        logic       adj;
        logic [3:0] sel;
        logic       add;
        logic       clr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    vec_t vecs[17];

    always #5 clk = ~clk;

    adjust_sequencer_if bus ();

    adjust_sequencer #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
        .REPEAT_RATE_MS(REPEAT_RATE_MS),
        .IDLE_TIMEOUT_MS(IDLE_TIMEOUT_MS)
    ) dut (
        .CLOCK_50(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic adj, input logic [3:0] sel,
                           input logic add, input logic clr);
        chk({name, ".adjust"}, {3'b000, bus.adjust}, {3'b000, adj});
        chk({name, ".select"}, bus.select, sel);
        chk({name, ".add"}, {3'b000, bus.add}, {3'b000, add});
        chk({name, ".clr"}, {3'b000, bus.clr}, {3'b000, clr});
    endtask

    // Advance one cycle; sample 1 time unit after the edge and check the
    // add/clr exclusivity and no-command-in-run invariants.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        n_checks++;
        if ((bus.add === 1'b1 && bus.clr === 1'b1) ||
            ((bus.add === 1'b1 || bus.clr === 1'b1) && bus.adjust !== 1'b1)) begin
            n_fail++;
            $display("FAIL invariant at cycle %0d: add=%b clr=%b adjust=%b, required add/clr exclusive and only in adjust",
                     cyc, bus.add, bus.clr, bus.adjust);
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 3, 1'b1, 4'd1, 1'b0, 1'b0};  // 3-cycle mode glitch
        vecs[1]  = '{4'b0010, 6, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[2]  = '{4'b0010, 6, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[3]  = '{4'b0010, 6, 1'b1, 4'd4, 1'b0, 1'b0};
        vecs[4]  = '{4'b0010, 6, 1'b1, 4'd5, 1'b0, 1'b0};
        vecs[5]  = '{4'b0010, 6, 1'b1, 4'd6, 1'b0, 1'b0};
        vecs[6]  = '{4'b0010, 6, 1'b1, 4'd7, 1'b0, 1'b0};
        vecs[7]  = '{4'b0010, 6, 1'b1, 4'd1, 1'b0, 1'b0};  // wrap 7 -> 1
        vecs[8]  = '{4'b1000, 6, 1'b1, 4'd1, 1'b0, 1'b1};  // clear
        vecs[9]  = '{4'b0100, 6, 1'b1, 4'd1, 1'b1, 1'b0};  // add, released before repeat
        vecs[10] = '{4'b1100, 6, 1'b1, 4'd1, 1'b0, 1'b1};  // KEY3 beats KEY2
        vecs[11] = '{4'b0110, 6, 1'b1, 4'd2, 1'b0, 1'b0};  // KEY1 beats KEY2
        vecs[12] = '{4'b1001, 6, 1'b0, 4'd0, 1'b0, 1'b0};  // KEY0 beats KEY3
        vecs[13] = '{4'b0010, 6, 1'b0, 4'd0, 1'b0, 1'b0};  // ignored in run
        vecs[14] = '{4'b0100, 6, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[15] = '{4'b1000, 6, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[16] = '{4'b0001, 4, 1'b1, 4'd1, 1'b0, 1'b0};  // shortest accepted press

        bus.KEY = 4'hF;
        rst = 1'b1;
        repeat (3) step();
        chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);

        // Latency: KEY0 falls in cycle 10, adjust/select appear in cycle 18.
        rst = 1'b0;
        cyc = 0;
        while (cyc < 10) step();
        bus.KEY = 4'b1110;
        while (cyc < 17) step();
        chk_out("latency_c17", 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        chk_out("latency_c18", 1'b1, 4'd1, 1'b0, 1'b0);
        while (cyc < 20) step();
        bus.KEY = 4'hF;
        while (cyc < 32) step();

        // Table: press, check the event cycle and that the command is single-cycle.
        for (int i = 0; i < 17; i++) begin
            bus.KEY = ~vecs[i].mask;
            for (int k = 1; k <= vecs[i].hold + 12; k++) begin
                step();
                if (k == vecs[i].hold) bus.KEY = 4'hF;
                if (k == 8) chk_out($sformatf("vec%0d", i), vecs[i].adj, vecs[i].sel,
                                    vecs[i].add, vecs[i].clr);
                if (k == 9) chk_out($sformatf("vec%0d_after", i), vecs[i].adj, vecs[i].sel,
                                    1'b0, 1'b0);
            end
        end

        // Auto-repeat: add at +8, +18, then every 3; release at +25 stops after +30.
        bus.KEY = 4'b1011;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 25) bus.KEY = 4'hF;
            chk($sformatf("repeat_add_k%0d", k), {3'b000, bus.add},
                {3'b000, (k == 8) || (k >= 18 && k <= 30 && (k - 18) % 3 == 0)});
        end
        chk_out("repeat_end", 1'b1, 4'd1, 1'b0, 1'b0);

        // Idle timeout: press at event+49 restarts the count; timeout 50 after it.
        bus.KEY = 4'b1101;
        for (int k = 1; k <= 110; k++) begin
            step();
            if (k == 6 || k == 55) bus.KEY = 4'hF;
            if (k == 49) bus.KEY = 4'b1101;
            if (k == 8)   chk_out("idle_first", 1'b1, 4'd2, 1'b0, 1'b0);
            if (k == 57)  chk_out("idle_restart", 1'b1, 4'd3, 1'b0, 1'b0);
            if (k == 58)  chk_out("idle_no_early", 1'b1, 4'd3, 1'b0, 1'b0);
            if (k == 106) chk_out("idle_c49", 1'b1, 4'd3, 1'b0, 1'b0);
            if (k == 107) chk_out("idle_timeout", 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // Reset during repeat with KEY2 still held.
        bus.KEY = 4'b1110;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 6) bus.KEY = 4'hF;
            if (k == 8) chk_out("rst_enter", 1'b1, 4'd1, 1'b0, 1'b0);
        end
        bus.KEY = 4'b1011;
        for (int k = 1; k <= 22; k++) begin
            step();
            chk($sformatf("rst_pre_add_k%0d", k), {3'b000, bus.add},
                {3'b000, (k == 8 || k == 18 || k == 21)});
        end
        rst = 1'b1;
        step();
        chk_out("rst_mid_repeat", 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("rst_held_run_k%0d", k), {3'b000, bus.add}, 4'd0);
        end
        bus.KEY = 4'b1010;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 6) bus.KEY = 4'b1011;
            if (k == 8) chk_out("rst_reenter", 1'b1, 4'd1, 1'b0, 1'b0);
            chk($sformatf("rst_held_adj_k%0d", k), {3'b000, bus.add}, 4'd0);
        end
        bus.KEY = 4'hF;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
